// File: rtl/vend_change_payout_if.sv
// vend_change_payout_if
//   Request/response channel between the vend FSM (master) and the change
//   payout block (slave).
//
//   Handshake: a request transfers on a rising clk edge where
//   req_valid & req_ready are both high. req_ready is high only while the
//   payout block is idle. Each accepted request ends with exactly one
//   done pulse. err and short_amt are valid in that same cycle, and
//   short_amt holds its value until the next request finishes.
//
//   Signals
//     req_valid  master->slave  change request valid
//     req_amt    master->slave  change amount to pay (AMT_W bits)
//     req_ready  slave->master  payout block idle, can accept a request
//     busy       slave->master  payout in progress
//     done       slave->master  one-cycle end-of-request pulse
//     err        slave->master  with done: payout incomplete
//     short_amt  slave->master  with done: unpaid remainder
interface vend_change_payout_if #(
  parameter int AMT_W = 5
);
  logic             req_valid;
  logic [AMT_W-1:0] req_amt;
  logic             req_ready;
  logic             busy;
  logic             done;
  logic             err;
  logic [AMT_W-1:0] short_amt;

  modport master (
    output req_valid, req_amt,
    input  req_ready, busy, done, err, short_amt
  );

  modport slave (
    input  req_valid, req_amt,
    output req_ready, busy, done, err, short_amt
  );
endinterface

// File: rtl/vend_change_payout.sv
// vend_change_payout
//   Change-return side of the vending controller. It accepts a change
//   amount from the vend FSM and pays it out one coin at a time from a
//   10-unit tube and a 5-unit tube. Each coin uses an eject pulse and then
//   waits for the exit sensor. The block also keeps the coin count of
//   each tube.
//
//   Ports
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     req                 request/response channel (vend_change_payout_if.slave)
//     eject5, eject10     one-cycle solenoid pulses, one coin per pulse
//     coin_seen           exit sensor pulse: the ejected coin was delivered
//     refill5, refill10   one coin added to a tube (saturating)
//     tube5_cnt           current coin count of the 5-unit tube
//     tube10_cnt          current coin count of the 10-unit tube
//     exact_only          present only with EXACT_CHANGE_EN: 5-unit tube empty
//     dbg_state           current FSM state encoding
//
//   Optional feature macro: EXACT_CHANGE_EN adds the exact_only output.
module vend_change_payout #(
  parameter int AMT_W         = 5,
  parameter int TUBE_W        = 4,
  parameter int TUBE5_INIT    = 8,
  parameter int TUBE10_INIT   = 4,
  parameter int EJECT_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  vend_change_payout_if.slave req,
  output logic              eject5,
  output logic              eject10,
  input  logic              coin_seen,
  input  logic              refill5,
  input  logic              refill10,
  output logic [TUBE_W-1:0] tube5_cnt,
  output logic [TUBE_W-1:0] tube10_cnt,
`ifdef EXACT_CHANGE_EN
  output logic              exact_only,
`endif
  output logic [2:0]        dbg_state
);

  localparam int TMR_W = $clog2(EJECT_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TIMEOUT  = TMR_W'(EJECT_TIMEOUT);
  localparam logic [TUBE_W-1:0] TUBE_MAX = '1;
  localparam logic [AMT_W-1:0]  FIVE     = AMT_W'(5);
  localparam logic [AMT_W-1:0]  TEN      = AMT_W'(10);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    EJECT  = 3'd2,
    WAIT   = 3'd3,
    FIN    = 3'd4,
    FAULT  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             coin10_q, coin10_d;  // coin in flight is a 10-unit coin
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             dec5, dec10;

  assign dbg_state     = state_q;
  assign req.req_ready = (state_q == IDLE);
  assign req.busy      = (state_q != IDLE);

  // Count update for one tube. A refill and a delivery in the same cycle
  // cancel each other out. Refill saturates at full scale. A delivery from
  // an empty tube cannot happen, but the zero guard keeps the count from
  // wrapping anyway.
  function automatic logic [TUBE_W-1:0] tube_next(input logic [TUBE_W-1:0] cnt,
                                                  input logic inc,
                                                  input logic dec);
    logic [TUBE_W-1:0] n;
    n = cnt;
    if (inc && !dec) begin
      if (cnt != TUBE_MAX) n = cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt != '0) n = cnt - 1'b1;
    end
    return n;
  endfunction

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    coin10_d = coin10_q;
    timer_d  = timer_q;
    dec5     = 1'b0;
    dec10    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req.req_valid && req.req_ready) begin
          rem_d   = req.req_amt;
          state_d = ((req.req_amt % FIVE) != '0) ? FAULT : SELECT;
        end
      end
      SELECT: begin
        // Prefer the larger coin. A coin is chosen only when rem covers
        // its value, so rem can never underflow.
        if (rem_q == '0) begin
          state_d = FIN;
        end else if (rem_q >= TEN && tube10_cnt != '0) begin
          coin10_d = 1'b1;
          state_d  = EJECT;
        end else if (rem_q >= FIVE && tube5_cnt != '0) begin
          coin10_d = 1'b0;
          state_d  = EJECT;
        end else begin
          state_d = FAULT;
        end
      end
      EJECT: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // If the coin arrives in the same cycle as the timeout, the coin
        // is accepted.
        if (coin_seen) begin
          rem_d   = rem_q - (coin10_q ? TEN : FIVE);
          dec10   = coin10_q;
          dec5    = !coin10_q;
          state_d = SELECT;
        end else if (timer_q == TIMEOUT) begin
          state_d = FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The pulse outputs are loaded from the next state. Each one is then high
  // for exactly the cycle the FSM spends in EJECT, FIN or FAULT, and it
  // still comes straight out of a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      coin10_q      <= 1'b0;
      timer_q       <= '0;
      tube5_cnt     <= TUBE_W'(TUBE5_INIT);
      tube10_cnt    <= TUBE_W'(TUBE10_INIT);
      eject5        <= 1'b0;
      eject10       <= 1'b0;
      req.done      <= 1'b0;
      req.err       <= 1'b0;
      req.short_amt <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      coin10_q   <= coin10_d;
      timer_q    <= timer_d;
      tube5_cnt  <= tube_next(tube5_cnt, refill5, dec5);
      tube10_cnt <= tube_next(tube10_cnt, refill10, dec10);
      eject5     <= (state_d == EJECT) && !coin10_d;
      eject10    <= (state_d == EJECT) && coin10_d;
      req.done   <= (state_d == FIN) || (state_d == FAULT);
      req.err    <= (state_d == FAULT);
      if (state_d == FIN) begin
        req.short_amt <= '0;
      end else if (state_d == FAULT) begin
        req.short_amt <= rem_d;
      end
    end
  end

`ifdef EXACT_CHANGE_EN
  // Goes high one cycle after the 5-unit tube becomes empty. The vend FSM
  // uses it to refuse payments that would need change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exact_only <= (TUBE5_INIT == 0);
    end else begin
      exact_only <= (tube5_cnt == '0);
    end
  end
`endif

endmodule

// File: tb/tb_vend_change_payout.sv
// tb_vend_change_payout
//   Directed testbench for vend_change_payout. Inputs change 1 ns after the
//   rising edge. Outputs are sampled on the falling edge.
module tb_vend_change_payout;

  logic       clk;
  logic       rst_n;
  logic       coin_seen, refill5, refill10;
  logic       eject5, eject10;
  logic [3:0] tube5_cnt, tube10_cnt;
  logic [2:0] dbg_state;
`ifdef EXACT_CHANGE_EN
  logic       exact_only;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Results of the most recent run_req call.
  int         r_n5, r_n10, r_first, r_done_cyc;
  logic       r_done, r_err, r_first10;
  logic [4:0] r_short;

  vend_change_payout_if #(.AMT_W(5)) bus ();

  vend_change_payout dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (bus),
    .eject5     (eject5),
    .eject10    (eject10),
    .coin_seen  (coin_seen),
    .refill5    (refill5),
    .refill10   (refill10),
    .tube5_cnt  (tube5_cnt),
    .tube10_cnt (tube10_cnt),
`ifdef EXACT_CHANGE_EN
    .exact_only (exact_only),
`endif
    .dbg_state  (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: sends one request and acts as the hopper until done appears.
  // The loop gives up after 100 cycles. Cycle 1 is the first cycle after
  // the handshake edge. If respond is set, coin_seen pulses 2 cycles after
  // each eject. If tie is set, refill5 pulses in the same cycle.
  task automatic run_req(input logic [4:0] amt, input bit respond, input bit tie);
    int cyc, pend;
    r_n5 = 0; r_n10 = 0; r_first = -1; r_done_cyc = -1;
    r_done = 1'b0; r_err = 1'b0; r_first10 = 1'b0; r_short = '0;
    cyc = 0; pend = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_amt = amt;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    while (!r_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (eject5 || eject10) begin
        if (r_first < 0) begin r_first = cyc; r_first10 = eject10; end
        if (eject5) r_n5++;
        if (eject10) r_n10++;
        if (respond) pend = 2;
      end
      if (bus.done) begin
        r_done = 1'b1; r_err = bus.err; r_short = bus.short_amt; r_done_cyc = cyc;
      end
      @(posedge clk); #1;
      coin_seen = 1'b0; refill5 = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin coin_seen = 1'b1; if (tie) refill5 = 1'b1; end
      end
    end
    coin_seen = 1'b0; refill5 = 1'b0;
  endtask

  task automatic pulse_refill(input bit five, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (five) refill5 = 1'b1; else refill10 = 1'b1;
      @(posedge clk); #1;
      refill5 = 1'b0; refill10 = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_amt = '0;
    coin_seen = 1'b0; refill5 = 1'b0; refill10 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if ({bus.busy, bus.done, bus.err, eject5, eject10} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {bus.busy, bus.done, bus.err, eject5, eject10}); end
    n_cmp++; if (bus.short_amt !== 5'd0) begin n_bad++; $display("FAIL reset_short: got %0d want 0", bus.short_amt); end
    n_cmp++; if ({tube5_cnt, tube10_cnt} !== {4'd8, 4'd4}) begin n_bad++; $display("FAIL reset_tubes: got %0d/%0d want 8/4", tube5_cnt, tube10_cnt); end
`ifdef EXACT_CHANGE_EN
    n_cmp++; if (exact_only !== 1'b0) begin n_bad++; $display("FAIL reset_exact: got %b want 0", exact_only); end
`endif
  endtask

  task automatic test_pay15();
    run_req(5'd15, 1'b1, 1'b0);
    n_cmp++; if (r_done !== 1'b1) begin n_bad++; $display("FAIL pay15_done: got %b want 1", r_done); end
    // The handshake cycle counts as cycle 1, so the eject comes in cycle 3,
    // which is loop cycle 2.
    n_cmp++; if (r_first !== 2) begin n_bad++; $display("FAIL pay15_latency: got %0d want 2", r_first); end
    n_cmp++; if (r_first10 !== 1'b1) begin n_bad++; $display("FAIL pay15_order: first10 got %b want 1", r_first10); end
    n_cmp++; if (r_n10 !== 1 || r_n5 !== 1) begin n_bad++; $display("FAIL pay15_coins: got %0d/%0d want 1/1", r_n10, r_n5); end
    n_cmp++; if (r_err !== 1'b0 || r_short !== 5'd0) begin n_bad++; $display("FAIL pay15_status: got err=%b short=%0d want 0/0", r_err, r_short); end
    n_cmp++; if ({tube5_cnt, tube10_cnt} !== {4'd7, 4'd3}) begin n_bad++; $display("FAIL pay15_tubes: got %0d/%0d want 7/3", tube5_cnt, tube10_cnt); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL pay15_done_width: got %b want 0", bus.done); end
  endtask

  task automatic test_odd_amt();
    run_req(5'd7, 1'b1, 1'b0);
    n_cmp++; if (r_done !== 1'b1 || r_done_cyc > 2) begin n_bad++; $display("FAIL odd_done: got done=%b cyc=%0d want 1 within 2", r_done, r_done_cyc); end
    n_cmp++; if (r_err !== 1'b1 || r_short !== 5'd7) begin n_bad++; $display("FAIL odd_status: got err=%b short=%0d want 1/7", r_err, r_short); end
    n_cmp++; if (r_n5 + r_n10 !== 0) begin n_bad++; $display("FAIL odd_ejects: got %0d want 0", r_n5 + r_n10); end
    n_cmp++; if ({tube5_cnt, tube10_cnt} !== {4'd7, 4'd3}) begin n_bad++; $display("FAIL odd_tubes: got %0d/%0d want 7/3", tube5_cnt, tube10_cnt); end
  endtask

  task automatic test_shortage();
    // 30 empties the 10-unit tube (3 coins). The first 20 then takes four
    // 5-unit coins (7 -> 3). The second 20 finds only three 5-unit coins.
    run_req(5'd30, 1'b1, 1'b0);
    n_cmp++; if (r_n10 !== 3 || r_err !== 1'b0 || tube10_cnt !== 4'd0) begin n_bad++; $display("FAIL drain10: got n10=%0d err=%b t10=%0d want 3/0/0", r_n10, r_err, tube10_cnt); end
    run_req(5'd20, 1'b1, 1'b0);
    n_cmp++; if (r_n5 !== 4 || r_err !== 1'b0 || tube5_cnt !== 4'd3) begin n_bad++; $display("FAIL pay20_fives: got n5=%0d err=%b t5=%0d want 4/0/3", r_n5, r_err, tube5_cnt); end
    run_req(5'd20, 1'b1, 1'b0);
    n_cmp++; if (r_n5 !== 3 || r_n10 !== 0) begin n_bad++; $display("FAIL short_coins: got %0d/%0d want 3/0", r_n5, r_n10); end
    n_cmp++; if (r_done !== 1'b1 || r_err !== 1'b1 || r_short !== 5'd5) begin n_bad++; $display("FAIL short_status: got done=%b err=%b short=%0d want 1/1/5", r_done, r_err, r_short); end
    n_cmp++; if (tube5_cnt !== 4'd0) begin n_bad++; $display("FAIL short_tube5: got %0d want 0", tube5_cnt); end
`ifdef EXACT_CHANGE_EN
    n_cmp++; if (exact_only !== 1'b1) begin n_bad++; $display("FAIL exact_set: got %b want 1", exact_only); end
`endif
    // short_amt keeps its value after done.
    n_cmp++; if (bus.short_amt !== 5'd5) begin n_bad++; $display("FAIL short_hold: got %0d want 5", bus.short_amt); end
  endtask

  task automatic test_refill();
    pulse_refill(1'b1, 3);
    n_cmp++; if (tube5_cnt !== 4'd3) begin n_bad++; $display("FAIL refill5: got %0d want 3", tube5_cnt); end
    pulse_refill(1'b0, 16);
    n_cmp++; if (tube10_cnt !== 4'd15) begin n_bad++; $display("FAIL refill10_sat: got %0d want 15", tube10_cnt); end
`ifdef EXACT_CHANGE_EN
    n_cmp++; if (exact_only !== 1'b0) begin n_bad++; $display("FAIL exact_clear: got %b want 0", exact_only); end
`endif
  endtask

  task automatic test_timeout();
    run_req(5'd5, 1'b0, 1'b0);
    n_cmp++; if (r_n5 !== 1 || r_n10 !== 0) begin n_bad++; $display("FAIL jam_coins: got %0d/%0d want 1/0", r_n5, r_n10); end
    n_cmp++; if (r_done !== 1'b1 || r_err !== 1'b1 || r_short !== 5'd5) begin n_bad++; $display("FAIL jam_status: got done=%b err=%b short=%0d want 1/1/5", r_done, r_err, r_short); end
    // Eject is in cycle 2, so after at least 15 WAIT cycles done can be in
    // cycle 18 at the earliest.
    n_cmp++; if (r_done_cyc < 18 || r_done_cyc > 20) begin n_bad++; $display("FAIL jam_time: got cyc %0d want 18..20", r_done_cyc); end
    n_cmp++; if (tube5_cnt !== 4'd3) begin n_bad++; $display("FAIL jam_tube5: got %0d want 3", tube5_cnt); end
  endtask

  task automatic test_refill_tie();
    run_req(5'd5, 1'b1, 1'b1);
    n_cmp++; if (r_err !== 1'b0 || r_n5 !== 1) begin n_bad++; $display("FAIL tie_status: got err=%b n5=%0d want 0/1", r_err, r_n5); end
    n_cmp++; if (tube5_cnt !== 4'd3) begin n_bad++; $display("FAIL tie_tube5: got %0d want 3", tube5_cnt); end
  endtask

  task automatic test_back_to_back();
    run_req(5'd10, 1'b1, 1'b0);
    n_cmp++; if (r_n10 !== 1 || r_err !== 1'b0 || tube10_cnt !== 4'd14) begin n_bad++; $display("FAIL b2b_10: got n10=%0d err=%b t10=%0d want 1/0/14", r_n10, r_err, tube10_cnt); end
    run_req(5'd25, 1'b1, 1'b0);
    n_cmp++; if (r_n10 !== 2 || r_n5 !== 1 || r_err !== 1'b0) begin n_bad++; $display("FAIL b2b_25: got %0d/%0d err=%b want 2/1/0", r_n10, r_n5, r_err); end
    n_cmp++; if ({tube5_cnt, tube10_cnt} !== {4'd2, 4'd12}) begin n_bad++; $display("FAIL b2b_tubes: got %0d/%0d want 2/12", tube5_cnt, tube10_cnt); end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    int cyc;
    seen_done = 0;
    cyc = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_amt = 5'd5;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.busy, bus.done, bus.err, eject5, eject10} !== 5'b0) begin n_bad++; $display("FAIL mid_flags: got %b want 00000", {bus.busy, bus.done, bus.err, eject5, eject10}); end
    n_cmp++; if ({tube5_cnt, tube10_cnt} !== {4'd8, 4'd4} || bus.short_amt !== 5'd0) begin n_bad++; $display("FAIL mid_regs: got %0d/%0d short=%0d want 8/4/0", tube5_cnt, tube10_cnt, bus.short_amt); end
    @(negedge clk); rst_n = 1'b1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.done) seen_done++;
    end
    n_cmp++; if (seen_done !== 0) begin n_bad++; $display("FAIL mid_no_done: got %0d want 0", seen_done); end
    // A stray sensor pulse while idle must not change any count.
    @(posedge clk); #1 coin_seen = 1'b1;
    @(posedge clk); #1 coin_seen = 1'b0;
    @(negedge clk);
    n_cmp++; if ({tube5_cnt, tube10_cnt} !== {4'd8, 4'd4}) begin n_bad++; $display("FAIL idle_seen: got %0d/%0d want 8/4", tube5_cnt, tube10_cnt); end
  endtask

  initial begin
    test_reset();
    test_pay15();
    test_odd_amt();
    test_shortage();
    test_refill();
    test_timeout();
    test_refill_tie();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
